// File: rtl/gf_sram_ctrl.sv
// gf_sram_ctrl: fabric-side controller for a GF180 single-port SRAM macro.
// RAM mode gives direct bit-masked access; FIFO mode arbitrates push/pop onto the single port.
module gf_sram_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 9,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 4
) (
  input  logic                  UserCLK,
  input  logic                  Reset,
  input  logic [1:0]            ConfigBits,
  input  logic                  EN,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] BM,
  input  logic                  WR_REQ,
  input  logic                  RD_REQ,
  input  logic [DATA_WIDTH-1:0] DI,
  output logic [DATA_WIDTH-1:0] DO,
  output logic                  DO_VALID,
  output logic                  WR_ACK,
  output logic                  RD_ACK,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  AFULL,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  CEN_SRAM,
  output logic                  GWEN_SRAM,
  output logic [DATA_WIDTH-1:0] WEN_SRAM,
  output logic [ADDR_WIDTH-1:0] A_SRAM,
  output logic [DATA_WIDTH-1:0] D_SRAM,
  input  logic [DATA_WIDTH-1:0] Q_SRAM,
  output logic                  CLK_SRAM
);

  localparam int                CW      = ADDR_WIDTH + 1;
  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0]     DEPTH_W = CW'(DEPTH);
  localparam logic [CW-1:0]     AFULL_W = CW'(AFULL_THRESH);

  typedef enum logic {
    ARB_WR_FIRST,
    ARB_RD_FIRST
  } arb_t;

  arb_t                  r_arb;
  arb_t                  w_arb_next;
  logic [CW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_rd_ptr;
  logic                  r_rd_pend;
  logic                  r_rd_pend2;
  logic [DATA_WIDTH-1:0] r_do;

  logic                  w_mode;
  logic                  w_outreg;
  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_elig;
  logic                  w_rd_elig;
  logic                  w_fifo_wr;
  logic                  w_fifo_rd;
  logic                  w_ram_wr;
  logic                  w_ram_rd;

  assign w_mode   = ConfigBits[0];
  assign w_outreg = ConfigBits[1];
  assign CLK_SRAM = UserCLK;

  // Occupancy comes from the wrap-bit pointers, so flags depend on registers only.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == DEPTH_W);
  assign w_empty = (w_count == '0);

  assign w_wr_elig = ~Reset & w_mode & WR_REQ & ~w_full;
  assign w_rd_elig = ~Reset & w_mode & RD_REQ & ~w_empty;
  assign w_fifo_wr = w_wr_elig & (~w_rd_elig | (r_arb == ARB_WR_FIRST));
  assign w_fifo_rd = w_rd_elig & ~w_fifo_wr;

  assign w_ram_wr = ~Reset & ~w_mode & EN & WE;
  assign w_ram_rd = ~Reset & ~w_mode & EN & ~WE;

  assign WR_ACK = w_ram_wr | w_fifo_wr;
  assign RD_ACK = w_ram_rd | w_fifo_rd;

  assign FULL  = w_mode & w_full;
  assign EMPTY = ~w_mode | w_empty;
  assign COUNT = w_mode ? w_count : '0;
  assign AFULL = w_mode ? (w_count >= AFULL_W) : (AFULL_THRESH == 0);

  always_comb begin
    CEN_SRAM  = 1'b1;
    GWEN_SRAM = 1'b1;
    WEN_SRAM  = '1;
    A_SRAM    = ADDR;
    D_SRAM    = DI;
    if (w_ram_wr || w_ram_rd) begin
      CEN_SRAM = 1'b0;
      if (w_ram_wr) begin
        GWEN_SRAM = 1'b0;
        WEN_SRAM  = ~BM;
      end
    end else if (w_fifo_wr) begin
      CEN_SRAM  = 1'b0;
      GWEN_SRAM = 1'b0;
      WEN_SRAM  = '0;
      A_SRAM    = r_wr_ptr[ADDR_WIDTH-1:0];
    end else if (w_fifo_rd) begin
      CEN_SRAM = 1'b0;
      A_SRAM   = r_rd_ptr[ADDR_WIDTH-1:0];
    end
  end

  always_comb begin
    w_arb_next = r_arb;
    if (!w_mode) begin
      w_arb_next = ARB_WR_FIRST;
    end else if (w_fifo_wr) begin
      w_arb_next = ARB_RD_FIRST;
    end else if (w_fifo_rd) begin
      w_arb_next = ARB_WR_FIRST;
    end
  end

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      r_arb <= ARB_WR_FIRST;
    end else begin
      r_arb <= w_arb_next;
    end
  end

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (!w_mode) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + CW'(1);
    end
  end

  // One capture register serves both DO modes: it is the hold value when
  // unregistered and the output register when OUTREG is set.
  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      r_rd_pend  <= 1'b0;
      r_rd_pend2 <= 1'b0;
      r_do       <= '0;
    end else begin
      r_rd_pend  <= w_ram_rd | w_fifo_rd;
      r_rd_pend2 <= r_rd_pend;
      if (r_rd_pend) r_do <= Q_SRAM;
    end
  end

  assign DO       = (!w_outreg && r_rd_pend) ? Q_SRAM : r_do;
  assign DO_VALID = w_outreg ? r_rd_pend2 : r_rd_pend;

endmodule

// File: tb/tb_gf_sram_ctrl.sv
// Self-checking bench for gf_sram_ctrl: RAM vector table, hand sequences and a
// queue-based FIFO scoreboard driven by random push/pop traffic against a macro model.
module tb_gf_sram_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;
  localparam int THR   = DEPTH - 4;

  logic          UserCLK = 1'b0;
  logic          Reset;
  logic [1:0]    ConfigBits;
  logic          EN, WE, WR_REQ, RD_REQ;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] BM, DI, DO;
  logic          DO_VALID, WR_ACK, RD_ACK, FULL, EMPTY, AFULL;
  logic [AW:0]   COUNT;
  logic          CEN_SRAM, GWEN_SRAM, CLK_SRAM;
  logic [DW-1:0] WEN_SRAM, D_SRAM, Q_SRAM;
  logic [AW-1:0] A_SRAM;

  gf_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(THR)) dut (
    .UserCLK(UserCLK), .Reset(Reset), .ConfigBits(ConfigBits),
    .EN(EN), .WE(WE), .ADDR(ADDR), .BM(BM),
    .WR_REQ(WR_REQ), .RD_REQ(RD_REQ), .DI(DI),
    .DO(DO), .DO_VALID(DO_VALID), .WR_ACK(WR_ACK), .RD_ACK(RD_ACK),
    .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL), .COUNT(COUNT),
    .CEN_SRAM(CEN_SRAM), .GWEN_SRAM(GWEN_SRAM), .WEN_SRAM(WEN_SRAM),
    .A_SRAM(A_SRAM), .D_SRAM(D_SRAM), .Q_SRAM(Q_SRAM), .CLK_SRAM(CLK_SRAM)
  );

  always #5 UserCLK = ~UserCLK;

  // Single-port macro: active-low enables, per-bit write mask, Q one cycle after a read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge CLK_SRAM) begin
    if (!CEN_SRAM) begin
      if (!GWEN_SRAM) mem[A_SRAM] <= (mem[A_SRAM] & WEN_SRAM) | (D_SRAM & ~WEN_SRAM);
      else            Q_SRAM      <= mem[A_SRAM];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic          en, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] bm, di;
    logic          e_wa, e_ra;
    logic [DW-1:0] e_wen;
    logic          e_dv;
    logic [DW-1:0] e_do;
  } ram_vec_t;

  function automatic ram_vec_t mk(input logic en, input logic we, input logic [AW-1:0] a,
                                  input logic [DW-1:0] bm, input logic [DW-1:0] di,
                                  input logic wa, input logic ra, input logic [DW-1:0] wen,
                                  input logic dv, input logic [DW-1:0] dout);
    ram_vec_t v;
    v.en = en; v.we = we; v.addr = a; v.bm = bm; v.di = di;
    v.e_wa = wa; v.e_ra = ra; v.e_wen = wen; v.e_dv = dv; v.e_do = dout;
    return v;
  endfunction

  // FIFO reference: data queue, last-grant flag, and reads awaiting delivery.
  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } pend_t;

  logic [DW-1:0] mq[$];
  pend_t         pq[$];
  logic          m_lw;
  int unsigned   cyc = 0;

  task automatic model_clear();
    mq.delete();
    pq.delete();
    m_lw = 1'b0;
  endtask

  // Called at a falling edge: drives one FIFO-mode cycle, checks it, advances the model.
  task automatic fifo_cycle(input logic wr, input logic rd, input logic [DW-1:0] d,
                            output logic wa, output logic ra);
    logic  e_full, e_empty, ew, er, g_w, g_r;
    pend_t p;
    EN = 1'b0; WE = 1'b0; WR_REQ = wr; RD_REQ = rd; DI = d;
    #1;
    e_full  = (mq.size() == DEPTH);
    e_empty = (mq.size() == 0);
    chk("fifo_full", 32'(FULL), 32'(e_full));
    chk("fifo_empty", 32'(EMPTY), 32'(e_empty));
    chk("fifo_count", 32'(COUNT), 32'(mq.size()));
    chk("fifo_afull", 32'(AFULL), 32'(mq.size() >= THR));
    ew  = wr && !e_full;
    er  = rd && !e_empty;
    g_w = ew && (!er || !m_lw);
    g_r = er && !g_w;
    chk("fifo_wr_ack", 32'(WR_ACK), 32'(g_w));
    chk("fifo_rd_ack", 32'(RD_ACK), 32'(g_r));
    if (pq.size() > 0 && pq[0].due == cyc) begin
      chk("fifo_do_valid", 32'(DO_VALID), 32'(1'b1));
      chk("fifo_do_data", 32'(DO), 32'(pq[0].data));
      void'(pq.pop_front());
    end else begin
      chk("fifo_do_valid", 32'(DO_VALID), 32'(1'b0));
    end
    if (g_w) mq.push_back(d);
    if (g_r) begin
      p.due  = cyc + (ConfigBits[1] ? 2 : 1);
      p.data = mq.pop_front();
      pq.push_back(p);
    end
    if (g_w || g_r) m_lw = g_w;
    wa = WR_ACK;
    ra = RD_ACK;
    cyc++;
    @(negedge UserCLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    ram_vec_t      tv[11];
    logic [DW-1:0] dat[3];
    logic          wa, ra, wr, rd, hold_w, hold_r, afull_seen, full_seen, empty_seen;

    Reset = 1'b1; ConfigBits = 2'b00; EN = 1'b0; WE = 1'b0; ADDR = '0; BM = '0;
    WR_REQ = 1'b0; RD_REQ = 1'b0; DI = '0;
    model_clear();

    tv[0]  = mk(1'b1, 1'b1, 9'h1A1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    tv[1]  = mk(1'b1, 1'b1, 9'h1A1, 8'h0F, 8'h00, 1'b1, 1'b0, 8'hF0, 1'b0, 8'h00);
    tv[2]  = mk(1'b1, 1'b0, 9'h1A1, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
    tv[3]  = mk(1'b0, 1'b0, 9'h000, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 8'hF0);
    tv[4]  = mk(1'b1, 1'b1, 9'h005, 8'hFF, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, 8'hF0);
    tv[5]  = mk(1'b1, 1'b0, 9'h005, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 8'hF0);
    tv[6]  = mk(1'b1, 1'b0, 9'h1A1, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h3C);
    tv[7]  = mk(1'b0, 1'b0, 9'h000, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 8'hF0);
    tv[8]  = mk(1'b0, 1'b1, 9'h0AA, 8'hFF, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 8'hF0);
    tv[9]  = mk(1'b1, 1'b0, 9'h005, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 8'hF0);
    tv[10] = mk(1'b0, 1'b0, 9'h000, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h3C);
    dat[0] = 8'hA1; dat[1] = 8'hB2; dat[2] = 8'hC3;

    // Reset values, with a RAM write presented while Reset is high.
    @(negedge UserCLK);
    EN = 1'b1; WE = 1'b1; ADDR = 9'h1A1; BM = 8'hFF;
    #1;
    chk("rst_cen", 32'(CEN_SRAM), 32'(1'b1));
    chk("rst_gwen", 32'(GWEN_SRAM), 32'(1'b1));
    chk("rst_wen", 32'(WEN_SRAM), 32'(8'hFF));
    chk("rst_wr_ack", 32'(WR_ACK), 32'(1'b0));
    chk("rst_rd_ack", 32'(RD_ACK), 32'(1'b0));
    chk("rst_do", 32'(DO), 32'(8'h00));
    chk("rst_do_valid", 32'(DO_VALID), 32'(1'b0));
    chk("rst_full", 32'(FULL), 32'(1'b0));
    chk("rst_empty", 32'(EMPTY), 32'(1'b1));
    chk("rst_afull", 32'(AFULL), 32'(1'b0));
    chk("rst_count", 32'(COUNT), 32'(0));
    chk("rst_clk_sram", 32'(CLK_SRAM), 32'(UserCLK));
    @(negedge UserCLK);
    Reset = 1'b0;

    // RAM mode, unregistered DO: bit mask and one-cycle read latency.
    for (int i = 0; i < 11; i++) begin
      EN = tv[i].en; WE = tv[i].we; ADDR = tv[i].addr; BM = tv[i].bm; DI = tv[i].di;
      #1;
      chk($sformatf("ram%0d_wr_ack", i), 32'(WR_ACK), 32'(tv[i].e_wa));
      chk($sformatf("ram%0d_rd_ack", i), 32'(RD_ACK), 32'(tv[i].e_ra));
      chk($sformatf("ram%0d_cen", i), 32'(CEN_SRAM), 32'(!tv[i].en));
      chk($sformatf("ram%0d_gwen", i), 32'(GWEN_SRAM), 32'(!(tv[i].en && tv[i].we)));
      chk($sformatf("ram%0d_wen", i), 32'(WEN_SRAM), 32'(tv[i].e_wen));
      if (tv[i].en) chk($sformatf("ram%0d_addr", i), 32'(A_SRAM), 32'(tv[i].addr));
      if (tv[i].en && tv[i].we) chk($sformatf("ram%0d_d", i), 32'(D_SRAM), 32'(tv[i].di));
      chk($sformatf("ram%0d_do_valid", i), 32'(DO_VALID), 32'(tv[i].e_dv));
      chk($sformatf("ram%0d_do", i), 32'(DO), 32'(tv[i].e_do));
      @(negedge UserCLK);
    end

    // RAM mode, registered DO: three back-to-back reads arrive two cycles later.
    ConfigBits = 2'b10;
    for (int k = 0; k < 3; k++) begin
      EN = 1'b1; WE = 1'b1; BM = 8'hFF; ADDR = 9'(9'h010 + k); DI = dat[k];
      #1;
      chk("oreg_wr_ack", 32'(WR_ACK), 32'(1'b1));
      @(negedge UserCLK);
    end
    for (int k = 0; k < 7; k++) begin
      EN = (k < 3); WE = 1'b0; ADDR = 9'(9'h010 + k);
      #1;
      chk($sformatf("oreg%0d_rd_ack", k), 32'(RD_ACK), 32'(k < 3));
      chk($sformatf("oreg%0d_do_valid", k), 32'(DO_VALID), 32'(k >= 2 && k <= 4));
      if (k >= 2 && k <= 4) chk($sformatf("oreg%0d_do", k), 32'(DO), 32'(dat[k-2]));
      @(negedge UserCLK);
    end
    EN = 1'b0;

    // FIFO fill to FULL, rejected push, drain in order.
    ConfigBits = 2'b01;
    model_clear();
    for (int i = 0; i < DEPTH; i++) fifo_cycle(1'b1, 1'b0, 8'(i), wa, ra);
    chk("fill_full", 32'(FULL), 32'(1'b1));
    chk("fill_count", 32'(COUNT), 32'(DEPTH));
    fifo_cycle(1'b1, 1'b0, 8'hEE, wa, ra);
    chk("full_push_noack", 32'(wa), 32'(1'b0));
    for (int i = 0; i < DEPTH; i++) fifo_cycle(1'b0, 1'b1, 8'h00, wa, ra);
    fifo_cycle(1'b0, 1'b0, 8'h00, wa, ra);
    chk("drain_empty", 32'(EMPTY), 32'(1'b1));
    fifo_cycle(1'b0, 1'b1, 8'h00, wa, ra);
    chk("empty_pop_noack", 32'(ra), 32'(1'b0));

    // Arbitration from a fresh reset: count 4 with a read as last grant, then hold both.
    Reset = 1'b1;
    @(negedge UserCLK);
    Reset = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++) fifo_cycle(1'b1, 1'b0, 8'(8'h30 + i), wa, ra);
    fifo_cycle(1'b0, 1'b1, 8'h00, wa, ra);
    for (int i = 0; i < 8; i++) begin
      fifo_cycle(1'b1, 1'b1, 8'(8'h40 + i), wa, ra);
      chk($sformatf("arb%0d_wr", i), 32'(wa), 32'(i % 2 == 0));
      chk($sformatf("arb%0d_rd", i), 32'(ra), 32'(i % 2 == 1));
      chk($sformatf("arb%0d_count_range", i), 32'(COUNT >= 4 && COUNT <= 5), 32'(1'b1));
    end

    // Pointer wrap: 3*DEPTH push/pop pairs.
    afull_seen = 1'b0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      fifo_cycle(1'b1, 1'b0, 8'($urandom), wa, ra);
      afull_seen = afull_seen | AFULL;
      fifo_cycle(1'b0, 1'b1, 8'h00, wa, ra);
      afull_seen = afull_seen | AFULL;
    end
    chk("wrap_afull_never", 32'(afull_seen), 32'(1'b0));
    fifo_cycle(1'b0, 1'b0, 8'h00, wa, ra);

    // Leaving FIFO mode clears its state; re-entry starts empty.
    ConfigBits = 2'b00;
    #1;
    chk("ram_flags_count", 32'(COUNT), 32'(0));
    chk("ram_flags_empty", 32'(EMPTY), 32'(1'b1));
    @(negedge UserCLK);
    ConfigBits = 2'b01;
    model_clear();
    #1;
    chk("reenter_count", 32'(COUNT), 32'(0));
    chk("reenter_empty", 32'(EMPTY), 32'(1'b1));
    @(negedge UserCLK);

    // Random traffic: fill-biased and drain-biased phases, both DO modes.
    full_seen = 1'b0; empty_seen = 1'b0;
    for (int ph = 0; ph < 4; ph++) begin
      if (ph == 2) ConfigBits = 2'b11;
      hold_w = 1'b0; hold_r = 1'b0;
      for (int n = 0; n < 1500; n++) begin
        wr = hold_w || ($urandom_range(99) < ((ph % 2 == 0) ? 85 : 20));
        rd = hold_r || ($urandom_range(99) < ((ph % 2 == 0) ? 20 : 85));
        fifo_cycle(wr, rd, 8'($urandom), wa, ra);
        hold_w = wr && !wa;
        hold_r = rd && !ra;
        full_seen  = full_seen | FULL;
        empty_seen = empty_seen | EMPTY;
      end
      for (int n = 0; n < 3; n++) fifo_cycle(1'b0, 1'b0, 8'h00, wa, ra);
    end
    chk("rand_reached_full", 32'(full_seen), 32'(1'b1));
    chk("rand_reached_empty", 32'(empty_seen), 32'(1'b1));

    // Asynchronous reset while a registered read is in flight.
    model_clear();
    ConfigBits = 2'b00;
    @(negedge UserCLK);
    ConfigBits = 2'b11;
    fifo_cycle(1'b1, 1'b0, 8'h11, wa, ra);
    fifo_cycle(1'b1, 1'b0, 8'h22, wa, ra);
    fifo_cycle(1'b0, 1'b1, 8'h00, wa, ra);
    Reset = 1'b1; WR_REQ = 1'b1; RD_REQ = 1'b1;
    #1;
    chk("mid_rst_do_valid", 32'(DO_VALID), 32'(1'b0));
    chk("mid_rst_do", 32'(DO), 32'(8'h00));
    chk("mid_rst_wr_ack", 32'(WR_ACK), 32'(1'b0));
    chk("mid_rst_rd_ack", 32'(RD_ACK), 32'(1'b0));
    chk("mid_rst_cen", 32'(CEN_SRAM), 32'(1'b1));
    chk("mid_rst_gwen", 32'(GWEN_SRAM), 32'(1'b1));
    chk("mid_rst_wen", 32'(WEN_SRAM), 32'(8'hFF));
    chk("mid_rst_count", 32'(COUNT), 32'(0));
    chk("mid_rst_empty", 32'(EMPTY), 32'(1'b1));
    chk("mid_rst_full", 32'(FULL), 32'(1'b0));
    chk("mid_rst_afull", 32'(AFULL), 32'(1'b0));
    @(negedge UserCLK);
    #1;
    chk("mid_rst_no_late_valid", 32'(DO_VALID), 32'(1'b0));
    @(negedge UserCLK);
    Reset = 1'b0;
    model_clear();
    fifo_cycle(1'b0, 1'b0, 8'h00, wa, ra);
    fifo_cycle(1'b0, 1'b0, 8'h00, wa, ra);
    fifo_cycle(1'b1, 1'b0, 8'h5A, wa, ra);
    chk("post_rst_push_ack", 32'(wa), 32'(1'b1));
    chk("post_rst_empty_clear", 32'(EMPTY), 32'(1'b0));
    fifo_cycle(1'b0, 1'b1, 8'h00, wa, ra);
    for (int n = 0; n < 3; n++) fifo_cycle(1'b0, 1'b0, 8'h00, wa, ra);
    chk("post_rst_pending_drained", 32'(pq.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
